// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t    : fetch FSM state encoding
//   INSTR_NOP        : instruction driven to the decoder when nothing is valid
//   DEFAULT_RESET_PC : default first fetch address
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH_REQ = 2'd0,
        WAIT_RSP  = 2'd1,
        HOLD      = 2'd2,
        DROP      = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if: request/response channel between the fetch unit and memory.
//   mem_req_valid/ready/addr : fetch request handshake, word-aligned address
//   mem_rsp_valid/data       : read data return, one per accepted request
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );

endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer: output register group presenting one instruction to decode.
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : capture instr_i/pc_i and raise valid_o
//   clear_i    : drop the held instruction (valid_o=0, instr_o=NOP)
//   instr_i    : instruction word to capture
//   pc_i       : address of instr_i
//   instr_o    : held instruction, NOP while not valid
//   pc_o       : address of instr_o
//   valid_o    : instr_o/pc_o are valid
// ---------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  valid_q;

    // Clear wins over load; the NOP is re-driven whenever the slot empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= DATA_WIDTH'(INSTR_NOP);
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            instr_q <= DATA_WIDTH'(INSTR_NOP);
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch: single-outstanding instruction fetch unit with redirect.
//   clk, rst    : clock, asynchronous active-high reset
//   mem         : memory request/response channel (master side)
//   instr       : instruction to the decoder (NOP while instr_valid=0)
//   instr_valid : instr and pc_out are valid
//   instr_ready : decoder consumes instr
//   pc_out      : address of instr
//   PCsrc       : branch/jump redirect strobe
//   pc_target   : redirect address, low two bits ignored
// ---------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_if.master         mem,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] pc_out,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] pc_target
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_valid_q, req_valid_d;
    logic                  drop_q, drop_d;
    logic                  buf_load;
    logic                  buf_clear;
    logic                  req_accept;
    logic [DATA_WIDTH-1:0] redirect_pc;

    assign req_accept  = req_valid_q && mem.mem_req_ready;
    assign redirect_pc = pc_target & ~DATA_WIDTH'(3);

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state, PC and buffer control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        req_addr_d = req_addr_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        case (state_q)
            FETCH_REQ: begin
                // The issued request cannot be withdrawn; remember to discard its data.
                if (PCsrc) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
                if (req_accept) begin
                    state_d = (drop_q || PCsrc) ? DROP : WAIT_RSP;
                    drop_d  = 1'b0;
                end
            end
            WAIT_RSP: begin
                if (PCsrc) begin
                    pc_d    = redirect_pc;
                    state_d = mem.mem_rsp_valid ? FETCH_REQ : DROP;
                end else if (mem.mem_rsp_valid) begin
                    buf_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // Redirect and consume together: instruction retires, pc takes the target.
                if (PCsrc) begin
                    pc_d      = redirect_pc;
                    buf_clear = 1'b1;
                    state_d   = FETCH_REQ;
                end else if (instr_ready) begin
                    pc_d      = pc_q + DATA_WIDTH'(4);
                    buf_clear = 1'b1;
                    state_d   = FETCH_REQ;
                end
            end
            DROP: begin
                // A redirect here only moves pc; the stale response still ends DROP.
                if (PCsrc) begin
                    pc_d = redirect_pc;
                end
                if (mem.mem_rsp_valid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        req_valid_d = (state_d == FETCH_REQ);
        // Address is latched only when a new request starts, so it holds while unaccepted.
        if (state_d == FETCH_REQ && state_q != FETCH_REQ) begin
            req_addr_d = pc_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;

    fetch_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (mem.mem_rsp_data),
        .pc_i    (pc_q),
        .instr_o (instr),
        .pc_o    (pc_out),
        .valid_o (instr_valid)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch: self-checking bench for instr_fetch. Delivered responses are
// queued as expected {instr, pc}; the monitor pops one per rising instr_valid.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_ready;
    logic        PCsrc;
    logic [31:0] pc_target;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    instr_fetch_if #(.DATA_WIDTH(32)) mem_if ();

    instr_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_if),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .PCsrc       (PCsrc),
        .pc_target   (pc_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rising instr_valid must match the oldest queued response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_instr_valid", {31'b0, instr_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", instr, e.instr);
                chk("sb_pc", pc_out, e.pc);
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic expect_req(input logic [31:0] addr);
        chk("req_valid", {31'b0, mem_if.mem_req_valid}, 32'h1);
        chk("req_addr", mem_if.mem_req_addr, addr);
    endtask

    task automatic accept_req();
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] data, input bit deliver, input logic [31:0] pc);
        if (deliver) exp_q.push_back('{instr: data, pc: pc});
        chk("pre_rsp_valid", {31'b0, instr_valid}, 32'h0);
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = data;
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b0;
    endtask

    task automatic consume(input int hold, input logic [31:0] data, input logic [31:0] addr);
        instr_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_instr", instr, data);
            chk("hold_pc", pc_out, addr);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_no_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("consumed_valid", {31'b0, instr_valid}, 32'h0);
        chk("consumed_nop", instr, INSTR_NOP);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int rdy_dly, input int rsp_dly, input int hold);
        expect_req(addr);
        repeat (rdy_dly) begin
            @(negedge clk);
            chk("req_addr_stable", mem_if.mem_req_addr, addr);
            chk("req_valid_stable", {31'b0, mem_if.mem_req_valid}, 32'h1);
        end
        accept_req();
        chk("wait_no_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        repeat (rsp_dly) @(negedge clk);
        send_rsp(data, 1'b1, addr);
        chk("instr_valid_latency", {31'b0, instr_valid}, 32'h1);
        consume(hold, data, addr);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        rst                  = 1'b1;
        instr_ready          = 1'b0;
        PCsrc                = 1'b0;
        pc_target            = 32'h0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_data  = 32'h0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_req_valid", {31'b0, mem_if.mem_req_valid}, 32'h0);
        chk("rst_req_addr", mem_if.mem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, INSTR_NOP);
        chk("rst_pc_out", pc_out, 32'h0);

        rst = 1'b0;
        @(negedge clk);

        // First fetch, response two cycles later, decoder stalls 5 cycles
        do_fetch(32'h0, 32'h0000_0093, 0, 2, 5);
        do_fetch(32'h4, 32'h0010_0113, 2, 0, 0);

        // Redirect while waiting for the response: it is dropped
        expect_req(32'h8);
        accept_req();
        PCsrc = 1'b1; pc_target = 32'h0000_0103;
        @(negedge clk);
        PCsrc = 1'b0;
        chk("drop_no_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        @(negedge clk);
        send_rsp(32'hDEAD_0001, 1'b0, 32'h0);
        chk("drop_instr_valid", {31'b0, instr_valid}, 32'h0);
        expect_req(32'h100);

        // Redirect together with the response in WAIT_RSP
        accept_req();
        PCsrc = 1'b1; pc_target = 32'h0000_0200;
        mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'hDEAD_0002;
        @(negedge clk);
        PCsrc = 1'b0; mem_if.mem_rsp_valid = 1'b0;
        chk("rsp_redir_valid", {31'b0, instr_valid}, 32'h0);
        expect_req(32'h200);

        // Redirect in FETCH_REQ while memory is not ready
        PCsrc = 1'b1; pc_target = 32'h0000_0300;
        @(negedge clk);
        PCsrc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_addr_old", mem_if.mem_req_addr, 32'h200);
            chk("stall_valid", {31'b0, mem_if.mem_req_valid}, 32'h1);
        end
        accept_req();
        chk("pend_drop_no_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        send_rsp(32'hDEAD_0003, 1'b0, 32'h0);
        chk("pend_drop_valid", {31'b0, instr_valid}, 32'h0);
        expect_req(32'h300);

        // Redirect on acceptance, then a second redirect while in DROP
        mem_if.mem_req_ready = 1'b1; PCsrc = 1'b1; pc_target = 32'h0000_0400;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0; PCsrc = 1'b0;
        PCsrc = 1'b1; pc_target = 32'h0000_0500;
        @(negedge clk);
        PCsrc = 1'b0;
        chk("drop_redir_no_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        send_rsp(32'hDEAD_0004, 1'b0, 32'h0);
        expect_req(32'h500);

        // Redirect and consume in the same HOLD cycle
        accept_req();
        send_rsp(32'h0050_0513, 1'b1, 32'h500);
        chk("hold_valid_500", {31'b0, instr_valid}, 32'h1);
        instr_ready = 1'b1; PCsrc = 1'b1; pc_target = 32'hFFFF_FFFF;
        @(negedge clk);
        instr_ready = 1'b0; PCsrc = 1'b0;
        chk("redir_consume_valid", {31'b0, instr_valid}, 32'h0);
        chk("redir_consume_nop", instr, INSTR_NOP);

        // Address wrap at the top of the space
        do_fetch(32'hFFFF_FFFC, 32'h0000_0513, 0, 1, 1);
        do_fetch(32'h0, 32'h0000_0011, 0, 0, 0);
        do_fetch(32'h4, 32'h0000_0022, 0, 0, 0);

        // Asynchronous reset in WAIT_RSP
        expect_req(32'h8);
        accept_req();
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'b0, mem_if.mem_req_valid}, 32'h0);
        chk("arst_req_addr", mem_if.mem_req_addr, 32'h0);
        chk("arst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_instr", instr, INSTR_NOP);
        chk("arst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'hDEAD_0005;
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b0;
        chk("stale_rsp_valid", {31'b0, instr_valid}, 32'h0);
        do_fetch(32'h0, 32'h0000_0033, 1, 0, 0);
        expect_req(32'h4);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have these ports:
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  DATA_WIDTH  word-aligned fetch address.
- mem_rsp_valid  in  1  read data valid; at most one per accepted request, any later cycle.
- mem_rsp_data  in  DATA_WIDTH  fetched instruction word.
- instr  out  DATA_WIDTH  instruction to the decoder.
- instr_valid  out  1  instr and pc_out are valid.
- instr_ready  in  1  decoder consumes instr.
- pc_out  out  DATA_WIDTH  address of instr.
- PCsrc  in  1  branch/jump redirect strobe from the control unit.
- pc_target  in  DATA_WIDTH  redirect address; sampled only when PCsrc=1.

Function
REQ-005 SHALL implement FSM states FETCH_REQ, WAIT_RSP, HOLD and DROP, with one request outstanding at most.
REQ-006 FETCH_REQ: mem_req_valid=1 and mem_req_addr=pc.
- On mem_req_ready=1 the request is accepted; next state is WAIT_RSP.
REQ-007 WAIT_RSP: on mem_rsp_valid=1, the next edge registers instr<=mem_rsp_data, pc_out<=pc, instr_valid<=1; next state is HOLD.
- Latency: instr_valid rises one cycle after mem_rsp_valid.
REQ-008 HOLD: instr, pc_out and instr_valid are held stable until instr_valid&&instr_ready.
- On acceptance: pc<=pc+4 (modulo 2^DATA_WIDTH, wrap 0xFFFF_FFFC->0), instr_valid<=0, next state FETCH_REQ.
REQ-009 While a request is unaccepted, mem_req_valid and mem_req_addr SHALL NOT change, including when a redirect arrives.
REQ-010 Redirect (PCsrc=1) has priority over all other events.
- pc<=pc_target with bits [1:0] forced to 0.
- instr_valid<=0 on the next edge; an unaccepted held instruction is discarded.
REQ-011 Redirect by state:
- HOLD: next state FETCH_REQ.
- WAIT_RSP without mem_rsp_valid: next state DROP.
- WAIT_RSP with mem_rsp_valid in the same cycle: response discarded; next state FETCH_REQ.
- FETCH_REQ, accepted or not: the old-address request completes and its response is dropped.
REQ-012 Redirect in FETCH_REQ:
- A pending-drop flag SHALL be set.
- On acceptance with the flag set, next state is DROP instead of WAIT_RSP.
REQ-013 DROP: the next mem_rsp_valid is discarded without updating instr; next state FETCH_REQ with the redirected pc.
REQ-014 A redirect in DROP SHALL update pc only; state is unchanged.
REQ-015 Redirect and instr_ready in the same HOLD cycle: the instruction counts as consumed, but pc SHALL take pc_target, not pc+4.
REQ-016 While instr_valid=0, instr SHALL drive NOP 32'h0000_0013.

Reset
REQ-017 On rst=1, regardless of clk:
- state=FETCH_REQ, pc=RESET_PC.
- mem_req_valid=0, mem_req_addr=RESET_PC.
- instr_valid=0, instr=NOP, pc_out=RESET_PC.
- Pending-drop flag cleared.
REQ-018 mem_req_valid SHALL first assert on the first clk edge after rst deasserts.
REQ-019 Reset mid-operation abandons any outstanding request.
- A response arriving after reset is ignored unless the FSM is in WAIT_RSP for a new request.

Structure
REQ-020 Package fetch_pkg SHALL hold:
- the state enum fetch_state_t;
- the NOP encoding INSTR_NOP;
- the default RESET_PC.
REQ-021 The HOLD register group (instr, pc_out, instr_valid) SHALL be sub-module fetch_buffer; the FSM and PC logic stay in instr_fetch.

Verification
REQ-022 Reset release, mem_req_ready=1, response 32'h0000_0093 two cycles later:
- mem_req_addr=0x0;
- instr_valid rises one cycle after mem_rsp_valid with instr=0x00000093, pc_out=0x0.
REQ-023 Hold instr_ready=0 for 5 cycles:
- instr and pc_out stay stable;
- no new mem_req_valid until acceptance;
- the next request uses addr 0x4.
REQ-024 PCsrc=1, pc_target=0x103 during WAIT_RSP:
- the arriving response is dropped (instr_valid stays 0);
- the next request uses addr 0x100.
REQ-025 PCsrc=1 during FETCH_REQ with mem_req_ready=0 for 3 cycles:
- the address stays old until accepted;
- its response is dropped;
- the following request uses pc_target.
REQ-026 pc=0xFFFF_FFFC accepted -> next request addr 0x0.
REQ-027 rst asserted in WAIT_RSP -> all outputs return to their reset values immediately, with no clk edge required.
